// File: rtl/morse_pkg.sv
// Shared types, character constants and the Morse-to-ASCII lookup
// for the Morse decoder core.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    DECODE = 2'd2,
    COMMIT = 2'd3
  } state_e;

  // Longest code the lookup table knows (six-element punctuation)
  localparam int unsigned LUT_SYM_MAX = 6;

  localparam logic [7:0] CHAR_NUL     = 8'h00;
  localparam logic [7:0] CHAR_INVALID = 8'h3F;

  // Bits are oldest-symbol-first from MSB to LSB of the used length,
  // dot = 0, dash = 1, so ".-" is 2'b01. Returns {valid, ascii}.
  function automatic logic [8:0] morse_lookup(input logic [2:0] len,
                                              input logic [5:0] bits);
    logic       valid;
    logic [7:0] ch;
    valid = 1'b1;
    ch    = CHAR_INVALID;
    case ({len, bits})
      {3'd1, 6'b000000}: ch = "E";
      {3'd1, 6'b000001}: ch = "T";
      {3'd2, 6'b000000}: ch = "I";
      {3'd2, 6'b000001}: ch = "A";
      {3'd2, 6'b000010}: ch = "N";
      {3'd2, 6'b000011}: ch = "M";
      {3'd3, 6'b000000}: ch = "S";
      {3'd3, 6'b000001}: ch = "U";
      {3'd3, 6'b000010}: ch = "R";
      {3'd3, 6'b000011}: ch = "W";
      {3'd3, 6'b000100}: ch = "D";
      {3'd3, 6'b000101}: ch = "K";
      {3'd3, 6'b000110}: ch = "G";
      {3'd3, 6'b000111}: ch = "O";
      {3'd4, 6'b000000}: ch = "H";
      {3'd4, 6'b000001}: ch = "V";
      {3'd4, 6'b000010}: ch = "F";
      {3'd4, 6'b000100}: ch = "L";
      {3'd4, 6'b000110}: ch = "P";
      {3'd4, 6'b000111}: ch = "J";
      {3'd4, 6'b001000}: ch = "B";
      {3'd4, 6'b001001}: ch = "X";
      {3'd4, 6'b001010}: ch = "C";
      {3'd4, 6'b001011}: ch = "Y";
      {3'd4, 6'b001100}: ch = "Z";
      {3'd4, 6'b001101}: ch = "Q";
      {3'd5, 6'b011111}: ch = "0";
      {3'd5, 6'b001111}: ch = "1";
      {3'd5, 6'b000111}: ch = "2";
      {3'd5, 6'b000011}: ch = "3";
      {3'd5, 6'b000001}: ch = "4";
      {3'd5, 6'b000000}: ch = "5";
      {3'd5, 6'b010000}: ch = "6";
      {3'd5, 6'b011000}: ch = "7";
      {3'd5, 6'b011100}: ch = "8";
      {3'd5, 6'b011110}: ch = "9";
      {3'd6, 6'b010101}: ch = ".";
      {3'd6, 6'b110011}: ch = ",";
      {3'd6, 6'b001100}: ch = "?";
      default: begin
        valid = 1'b0;
        ch    = CHAR_INVALID;
      end
    endcase
    return {valid, ch};
  endfunction

endpackage

// File: rtl/morse_decoder_core_lut.sv
// Combinational wrapper around morse_lookup, adapting the accumulator
// width to the fixed-width lookup table.
module morse_lut
  import morse_pkg::*;
#(
  parameter int unsigned MAX_SYMBOLS = 6,
  parameter int unsigned CHAR_W      = 8,
  parameter int unsigned LEN_W       = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic [LEN_W-1:0]       sym_len,
  input  logic [MAX_SYMBOLS-1:0] sym_bits,
  output logic                   valid,
  output logic [CHAR_W-1:0]      ch
);

  logic [LUT_SYM_MAX-1:0] bits_ext;
  logic [8:0]             res;

  always_comb begin
    bits_ext = '0;
    for (int unsigned i = 0; i < LUT_SYM_MAX; i++) begin
      if (i < MAX_SYMBOLS) bits_ext[i] = sym_bits[i];
    end
    // Codes longer than the table are invalid by definition
    if (32'(sym_len) > LUT_SYM_MAX) res = {1'b0, CHAR_INVALID};
    else                            res = morse_lookup(3'(sym_len), bits_ext);
    valid = res[8];
    ch    = CHAR_W'(res[7:0]);
  end

endmodule

// File: rtl/morse_decoder_core.sv
// Morse symbol accumulator with registered decode and a shift-on-full
// text buffer feeding the display driver.
module morse_decoder_core
  import morse_pkg::*;
#(
  parameter int unsigned MAX_SYMBOLS = 6,
  parameter int unsigned TEXT_DEPTH  = 8,
  parameter int unsigned CHAR_W      = 8,
  localparam int unsigned LEN_W      = $clog2(MAX_SYMBOLS + 1),
  localparam int unsigned CNT_W      = $clog2(TEXT_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         turn_on,
  input  logic                         dot,
  input  logic                         dash,
  input  logic                         confirm,
  input  logic                         backspace,
  input  logic                         clear,
  output logic [MAX_SYMBOLS-1:0]       sym_bits,
  output logic [LEN_W-1:0]             sym_len,
  output logic [TEXT_DEPTH*CHAR_W-1:0] text,
  output logic [CNT_W-1:0]             text_count,
  output logic                         char_valid,
  output logic [CHAR_W-1:0]            char_out,
  output logic                         busy,
  output logic                         err
);

  state_e                               state_q, state_d;
  logic [MAX_SYMBOLS-1:0]               sym_bits_q, sym_bits_d;
  logic [LEN_W-1:0]                     sym_len_q, sym_len_d;
  logic [TEXT_DEPTH-1:0][CHAR_W-1:0]    text_q, text_d;
  logic [CNT_W-1:0]                     text_count_q, text_count_d;
  logic                                 char_valid_q, char_valid_d;
  logic [CHAR_W-1:0]                    char_out_q, char_out_d;
  logic                                 err_q, err_d;
  logic                                 lut_valid_q, lut_valid_d;
  logic [CHAR_W-1:0]                    lut_char_q, lut_char_d;
  logic                                 lut_valid;
  logic [CHAR_W-1:0]                    lut_char;

  morse_lut #(
    .MAX_SYMBOLS(MAX_SYMBOLS),
    .CHAR_W     (CHAR_W),
    .LEN_W      (LEN_W)
  ) u_lut (
    .sym_len (sym_len_q),
    .sym_bits(sym_bits_q),
    .valid   (lut_valid),
    .ch      (lut_char)
  );

  always_comb begin
    state_d      = state_q;
    sym_bits_d   = sym_bits_q;
    sym_len_d    = sym_len_q;
    text_d       = text_q;
    text_count_d = text_count_q;
    char_valid_d = 1'b0;
    char_out_d   = char_out_q;
    err_d        = 1'b0;
    lut_valid_d  = lut_valid_q;
    lut_char_d   = lut_char_q;

    // Clear outranks everything, including an in-flight decode
    if (turn_on && clear) begin
      state_d      = IDLE;
      sym_bits_d   = '0;
      sym_len_d    = '0;
      text_d       = '0;
      text_count_d = '0;
    end else begin
      case (state_q)
        DECODE: begin
          lut_valid_d = lut_valid;
          lut_char_d  = lut_char;
          state_d     = COMMIT;
        end
        COMMIT: begin
          state_d    = IDLE;
          sym_bits_d = '0;
          sym_len_d  = '0;
          if (lut_valid_q) begin
            char_valid_d = 1'b1;
            char_out_d   = lut_char_q;
            if (text_count_q < CNT_W'(TEXT_DEPTH)) begin
              for (int unsigned i = 0; i < TEXT_DEPTH; i++) begin
                if (CNT_W'(i) == text_count_q) text_d[i] = lut_char_q;
              end
              text_count_d = text_count_q + CNT_W'(1);
            end else begin
              for (int unsigned i = 0; i + 1 < TEXT_DEPTH; i++) begin
                text_d[i] = text_q[i+1];
              end
              text_d[TEXT_DEPTH-1] = lut_char_q;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          if (turn_on) begin
            if (backspace) begin
              if (sym_len_q != '0) begin
                sym_bits_d = sym_bits_q >> 1;
                sym_len_d  = sym_len_q - LEN_W'(1);
                if (sym_len_q == LEN_W'(1)) state_d = IDLE;
              end else if (text_count_q != '0) begin
                text_count_d = text_count_q - CNT_W'(1);
                for (int unsigned i = 0; i < TEXT_DEPTH; i++) begin
                  if (CNT_W'(i + 1) == text_count_q) text_d[i] = '0;
                end
              end
            end else if (confirm) begin
              if (sym_len_q != '0) state_d = DECODE;
            end else if (dash || dot) begin
              if (sym_len_q == LEN_W'(MAX_SYMBOLS)) begin
                err_d = 1'b1;
              end else begin
                sym_bits_d = {sym_bits_q[MAX_SYMBOLS-2:0], dash};
                sym_len_d  = sym_len_q + LEN_W'(1);
                state_d    = ENTRY;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sym_bits_q   <= '0;
      sym_len_q    <= '0;
      text_q       <= '0;
      text_count_q <= '0;
      char_valid_q <= 1'b0;
      char_out_q   <= '0;
      err_q        <= 1'b0;
      lut_valid_q  <= 1'b0;
      lut_char_q   <= '0;
    end else begin
      state_q      <= state_d;
      sym_bits_q   <= sym_bits_d;
      sym_len_q    <= sym_len_d;
      text_q       <= text_d;
      text_count_q <= text_count_d;
      char_valid_q <= char_valid_d;
      char_out_q   <= char_out_d;
      err_q        <= err_d;
      lut_valid_q  <= lut_valid_d;
      lut_char_q   <= lut_char_d;
    end
  end

  assign sym_bits   = sym_bits_q;
  assign sym_len    = sym_len_q;
  assign text       = text_q;
  assign text_count = text_count_q;
  assign char_valid = char_valid_q;
  assign char_out   = char_out_q;
  assign err        = err_q;
  assign busy       = (state_q == DECODE) || (state_q == COMMIT);

endmodule

// File: tb/tb_morse_decoder_core.sv
// Table-driven bench for morse_decoder_core with a queue scoreboard for
// committed characters and error pulses.
module tb_morse_decoder_core;

  localparam int MS = 6;
  localparam int TD = 8;
  localparam int CW = 8;

  localparam int D   = 1;
  localparam int H   = 2;
  localparam int C   = 4;
  localparam int B   = 8;
  localparam int X   = 16;
  localparam int OFF = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              turn_on = 1'b1;
  logic              dot = 1'b0, dash = 1'b0, confirm = 1'b0;
  logic              backspace = 1'b0, clear = 1'b0;
  logic [MS-1:0]     sym_bits;
  logic [2:0]        sym_len;
  logic [TD*CW-1:0]  text;
  logic [3:0]        text_count;
  logic              char_valid;
  logic [CW-1:0]     char_out;
  logic              busy;
  logic              err;

  morse_decoder_core #(
    .MAX_SYMBOLS(MS),
    .TEXT_DEPTH (TD),
    .CHAR_W     (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .turn_on   (turn_on),
    .dot       (dot),
    .dash      (dash),
    .confirm   (confirm),
    .backspace (backspace),
    .clear     (clear),
    .sym_bits  (sym_bits),
    .sym_len   (sym_len),
    .text      (text),
    .text_count(text_count),
    .char_valid(char_valid),
    .char_out  (char_out),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cmd;
    int         len;
    logic [5:0] bits;
    logic [7:0] ch;
    bit         er;
  } vec_t;

  vec_t       tbl[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] char_q[$];
  int         err_expect = 0;
  logic [7:0] model[$];
  logic [7:0] exp_ch;
  int         prev_len = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_text();
    logic [63:0] v;
    v = '0;
    foreach (model[i]) v[i*8 +: 8] = model[i];
    return v;
  endfunction

  function automatic void add(input int cmd, input int len, input logic [5:0] bits,
                              input logic [7:0] ch, input bit er);
    vec_t v;
    v.cmd = cmd; v.len = len; v.bits = bits; v.ch = ch; v.er = er;
    tbl.push_back(v);
  endfunction

  // Scoreboard: pop expected characters / error tokens as the DUT emits them
  always @(negedge clk) begin
    if (rst_n && char_valid) begin
      if (char_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL char_unexpected: got char %0h, expected no commit", char_out);
      end else begin
        exp_ch = char_q.pop_front();
        check("char_out", char_out, exp_ch);
      end
    end
    if (rst_n && err) begin
      checks++;
      if (err_expect == 0) begin
        errors++;
        $display("FAIL err_unexpected: got err=1, expected 0");
      end else begin
        err_expect--;
      end
    end
  end

  task automatic pulse(input int cmd);
    @(negedge clk);
    turn_on   = (cmd & OFF) == 0;
    dot       = (cmd & D) != 0;
    dash      = (cmd & H) != 0;
    confirm   = (cmd & C) != 0;
    backspace = (cmd & B) != 0;
    clear     = (cmd & X) != 0;
    @(negedge clk);
    {dot, dash, confirm, backspace, clear} = '0;
    turn_on = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Symbol entry, decode, overflow, backspace
    add(D, 1, 6'b0, 0, 0);
    add(H, 2, 6'b01, 0, 0);
    add(C, 0, 6'b0, 8'h41, 0);
    add(H, 1, 6'h01, 0, 0);
    add(H, 2, 6'h03, 0, 0);
    add(H, 3, 6'h07, 0, 0);
    add(H, 4, 6'h0f, 0, 0);
    add(H, 5, 6'h1f, 0, 0);
    add(C, 0, 6'b0, 8'h30, 0);
    for (int i = 1; i <= 6; i++) add(D, i, 6'b0, 0, 0);
    add(D, 6, 6'b0, 0, 1);
    add(B, 5, 6'b0, 0, 0);
    add(X, 0, 6'b0, 0, 0);
    add(H, 1, 6'b1, 0, 0);
    add(D, 2, 6'b10, 0, 0);
    add(B, 1, 6'b1, 0, 0);
    add(B, 0, 6'b0, 0, 0);
    add(D, 1, 6'b0, 0, 0);
    add(C, 0, 6'b0, 8'h45, 0);
    add(H, 1, 6'b1, 0, 0);
    add(C, 0, 6'b0, 8'h54, 0);
    add(D, 1, 6'b0, 0, 0);
    add(D, 2, 6'b0, 0, 0);
    add(C, 0, 6'b0, 8'h49, 0);
    add(D, 1, 6'b0, 0, 0);
    add(B, 0, 6'b0, 0, 0);
    add(B, 0, 6'b0, 0, 0);
    // Invalid code, simultaneous pulses, turn_on gating, idle confirm
    add(H, 1, 6'h01, 0, 0);
    add(H, 2, 6'h03, 0, 0);
    add(H, 3, 6'h07, 0, 0);
    add(H, 4, 6'h0f, 0, 0);
    add(H, 5, 6'h1f, 0, 0);
    add(H, 6, 6'h3f, 0, 0);
    add(C, 0, 6'b0, 0, 1);
    add(D | H, 1, 6'b1, 0, 0);
    add(X | B | C | H | D, 0, 6'b0, 0, 0);
    add(D, 1, 6'b0, 0, 0);
    add(B | C, 0, 6'b0, 0, 0);
    add(D, 1, 6'b0, 0, 0);
    add(C | H, 0, 6'b0, 8'h45, 0);
    add(D, 1, 6'b0, 0, 0);
    add(OFF | D, 1, 6'b0, 0, 0);
    add(OFF | X, 1, 6'b0, 0, 0);
    add(C, 0, 6'b0, 8'h45, 0);
    add(C, 0, 6'b0, 0, 0);
    add(X, 0, 6'b0, 0, 0);
    add(B, 0, 6'b0, 0, 0);
    // Fill past capacity with alternating E/T, ending in T
    for (int i = 0; i < TD + 1; i++) begin
      if ((i % 2) == 1 || i == TD) begin
        add(H, 1, 6'b1, 0, 0);
        add(C, 0, 6'b0, 8'h54, 0);
      end else begin
        add(D, 1, 6'b0, 0, 0);
        add(C, 0, 6'b0, 8'h45, 0);
      end
    end

    // Reset state
    @(posedge clk); #1;
    check("rst_sym_bits", sym_bits, 0);
    check("rst_sym_len", sym_len, 0);
    check("rst_text", text, 0);
    check("rst_text_count", text_count, 0);
    check("rst_char_valid", char_valid, 0);
    check("rst_char_out", char_out, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      int cmd;
      cmd = tbl[k].cmd;
      if ((cmd & OFF) == 0) begin
        if ((cmd & X) != 0) model.delete();
        else if ((cmd & B) != 0) begin
          if (prev_len == 0 && model.size() > 0) void'(model.pop_back());
        end else if ((cmd & C) != 0 && tbl[k].ch != 0) begin
          char_q.push_back(tbl[k].ch);
          model.push_back(tbl[k].ch);
          if (model.size() > TD) void'(model.pop_front());
        end
      end
      if (tbl[k].er) err_expect++;
      pulse(cmd);
      wait_cycles(3);
      check($sformatf("v%0d_sym_len", k), sym_len, tbl[k].len);
      check($sformatf("v%0d_sym_bits", k), sym_bits, tbl[k].bits);
      check($sformatf("v%0d_text_count", k), text_count, model.size());
      check($sformatf("v%0d_text", k), text, model_text());
      prev_len = tbl[k].len;
    end

    check("full_count", text_count, TD);
    check("full_slot7", text[63:56], 8'h54);
    check("full_slot0", text[7:0], 8'h54);
    pulse(B);
    void'(model.pop_back());
    wait_cycles(2);
    check("bs_full_count", text_count, TD - 1);
    check("bs_full_text", text, model_text());

    // Confirm-to-character latency and busy window
    pulse(X);
    model.delete();
    pulse(D);
    @(negedge clk);
    confirm = 1'b1;
    char_q.push_back(8'h45);
    model.push_back(8'h45);
    @(posedge clk); #1;
    confirm = 1'b0;
    check("lat_busy_decode", busy, 1);
    check("lat_cv_decode", char_valid, 0);
    @(posedge clk); #1;
    check("lat_busy_commit", busy, 1);
    check("lat_cv_commit", char_valid, 0);
    check("lat_count_commit", text_count, 0);
    @(posedge clk); #1;
    check("lat_cv", char_valid, 1);
    check("lat_char", char_out, 8'h45);
    check("lat_busy_done", busy, 0);
    check("lat_count", text_count, 1);
    @(posedge clk); #1;
    check("lat_cv_drop", char_valid, 0);

    // Clear during DECODE aborts the character
    pulse(X);
    model.delete();
    pulse(D);
    @(negedge clk);
    confirm = 1'b1;
    @(negedge clk);
    confirm = 1'b0;
    check("abort_busy", busy, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_cycles(3);
    check("abort_len", sym_len, 0);
    check("abort_count", text_count, 0);
    check("abort_busy_done", busy, 0);

    // turn_on dropped while a decode is in flight
    pulse(H);
    @(negedge clk);
    confirm = 1'b1;
    char_q.push_back(8'h54);
    model.push_back(8'h54);
    @(negedge clk);
    confirm = 1'b0;
    turn_on = 1'b0;
    wait_cycles(4);
    turn_on = 1'b1;
    check("off_inflight_count", text_count, 1);
    check("off_inflight_text", text, model_text());

    // Asynchronous reset mid-decode
    pulse(D);
    @(negedge clk);
    confirm = 1'b1;
    @(posedge clk); #1;
    confirm = 1'b0;
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_len", sym_len, 0);
    check("arst_count", text_count, 0);
    check("arst_text", text, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model.delete();
    wait_cycles(4);
    check("arst_cv", char_valid, 0);

    check("char_queue_empty", char_q.size(), 0);
    check("err_expect_empty", err_expect, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_decoder_core.md
# morse_decoder_core

Clocked, parametrised successor to the button-level decoder front end. It accepts single-cycle dot, dash, confirm, backspace and clear pulses from the debounced push-button layer. It accumulates the current Morse symbol sequence and decodes it to ASCII on confirm through a registered lookup stage. Decoded characters go into a scrolling text buffer that feeds the seven-segment/LED display driver.

## Interface
- MAX_SYMBOLS, 6: capacity of the symbol accumulator. Must be at least 5. The default of 6 covers letters, digits and six-element punctuation.
- TEXT_DEPTH, 8: number of characters held in the text buffer.
- CHAR_W, 8: character width (ASCII).
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- turn_on  in  1  decoder mode enable. When low, all command pulses are ignored and all state is held.
- dot  in  1  one-cycle pulse: append a dot.
- dash  in  1  one-cycle pulse: append a dash.
- confirm  in  1  one-cycle pulse: decode the current sequence.
- backspace  in  1  one-cycle pulse: delete the last symbol, or the last character if no symbols are pending.
- clear  in  1  one-cycle pulse: empty the accumulator and the text buffer.
- sym_bits  out  MAX_SYMBOLS  pending symbols: 0 = dot, 1 = dash. Bit 0 is the newest symbol.
- sym_len  out  $clog2(MAX_SYMBOLS+1)  number of pending symbols.
- text  out  TEXT_DEPTH*CHAR_W  buffer contents. Slot 0 is in bits [CHAR_W-1:0] and holds the oldest character.
- text_count  out  $clog2(TEXT_DEPTH+1)  number of valid characters.
- char_valid  out  1  one-cycle pulse when a character is committed.
- char_out  out  CHAR_W  the committed character; valid while char_valid is high.
- busy  out  1  high while in DECODE or COMMIT.
- err  out  1  one-cycle pulse on symbol overflow or invalid code.

## Operation
- FSM states and transitions:
  - IDLE (sym_len = 0): dot or dash moves to ENTRY.
  - ENTRY: confirm moves to DECODE; backspace that removes the only remaining symbol moves to IDLE.
  - DECODE: the registered lookup of {sym_len, sym_bits} completes; moves to COMMIT.
  - COMMIT: result is applied; moves to IDLE.
- Dot/dash: sym_bits <= {sym_bits[MAX_SYMBOLS-2:0], dash}; sym_len increments.
  - If sym_len = MAX_SYMBOLS, the symbol is dropped, err pulses, and the state is unchanged.
- Confirm in IDLE (empty accumulator) is ignored. No err.
- COMMIT with a valid code:
  - If text_count < TEXT_DEPTH, the character is written to slot text_count and text_count increments.
  - If the buffer is full, slots shift down by one (oldest discarded), the new character goes into slot TEXT_DEPTH-1, and text_count stays at TEXT_DEPTH.
  - char_valid pulses with char_out = the character.
  - The accumulator clears.
- COMMIT with an invalid code: nothing is written, err pulses, and the accumulator clears.
- Backspace, in order of precedence:
  - If sym_len > 0: sym_bits <= sym_bits >> 1; sym_len decrements.
  - Else if text_count > 0: text_count decrements. The vacated slot is zeroed.
  - Else: no effect.
- Clear: accumulator and text buffer are zeroed; FSM returns to IDLE.
- Simultaneous pulses in the same cycle: only one command acts. Priority is clear > backspace > confirm > dash > dot; the others are discarded.
- In DECODE or COMMIT: all pulses except clear are ignored.
  - Clear aborts the decode: no char_valid and no err.
- turn_on low: pulses are ignored. An in-flight DECODE/COMMIT still completes.
- Unused sym_bits above sym_len always read 0.

## Timing
- Reset values: every output is 0 (sym_bits, sym_len, text, text_count, char_valid, char_out, busy, err). FSM is in IDLE.
- Reset asserted mid-decode aborts immediately and asynchronously.
- Dot, dash, backspace and clear take effect on the outputs in the cycle after the pulse is sampled.
- Confirm sampled at edge N:
  - DECODE during cycle N+1, with busy = 1.
  - COMMIT at edge N+2: text and text_count update, char_valid = 1 for one cycle.
  - busy falls after edge N+2.
- Confirm-to-character latency is 2 cycles. Maximum rate is one confirm per 3 cycles.
- err is registered. It pulses in the cycle after an overflow, or in the cycle after COMMIT for an invalid code.

## Structure
- Shared package morse_pkg contains:
  - FSM state enum (IDLE, ENTRY, DECODE, COMMIT).
  - ASCII constants, including CHAR_INVALID = 8'h3F.
  - Function morse_lookup(len, bits) returning {valid, ascii}. It covers A–Z, 0–9 and . , ?
- Sub-module morse_lut: combinational wrapper around morse_lookup. The core registers its output in DECODE.
- Text buffer is an in-module register array with shift-on-full. No FIFO instance.

## Test plan
- dot, dash, confirm → char_valid 2 cycles after confirm, char_out = 8'h41 ('A'), text_count = 1.
- dash×5, confirm → char_out = 8'h30 ('0'). dot×7 → 7th dot gives an err pulse, sym_len stays 6, sym_bits = 6'b000000.
- Fill the buffer with TEXT_DEPTH+1 'E' (a single dot each). Make the last one 'T' → text_count = 8, slot 7 = 8'h54, oldest 'E' shifted out.
- dash, dot, backspace → sym_len = 1, sym_bits = 1. Backspace twice with text_count = 3 → sym_len = 0, then text_count = 2.
- dot, confirm, and clear in the DECODE cycle → no char_valid, text_count unchanged (0), state IDLE. Dot and dash pulsed in the same cycle → only a dash is appended.
- dash×6, confirm (invalid code) → err pulse, no char_valid, sym_len = 0. turn_on = 0 with dot pulses → sym_len unchanged.
